multirate_mac_sched: RTL and testbench

Time-multiplexed MAC scheduler for one decimating FIR branch of the multirate filterbank. It buffers input samples in a circular delay line. Once every DECIM accepted samples, it sequences NTAPS products through the shared external 16s x 15u combinational multiplier (31-bit signed product, zero stages) and accumulates them. It then rounds, saturates and emits one output sample through a valid/ready port. The coefficient ROM is external and registered (1-cycle read); a bank select lets one scheduler serve several filter banks.

---
 rtl/multirate_pkg.sv | 13 +
 rtl/multirate_round_sat.sv | 20 ++
 rtl/multirate_mac_sched.sv | 130 +++++++++++++
 tb/tb_multirate_mac_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multirate_pkg.sv
// multirate_pkg: shared datapath widths, scheduler states and a clog2 helper
package multirate_pkg;
    localparam int SAMPLE_W = 16;
    localparam int COEF_W = 15;
    localparam int PROD_W = 31;
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/multirate_round_sat.sv
// multirate_round_sat: round-half-up right shift of the accumulator, clamped to the output range
module multirate_round_sat #(
    parameter int ACC_W = 36,
    parameter int OUT_SHIFT = 14,
    parameter int OUT_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] out_o
);
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;
    always_comb begin
        sum = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
        r = sum >>> OUT_SHIFT;
        out_o = r > MAXV ? MAXV[OUT_W-1:0] : r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
    end
endmodule

// File: rtl/multirate_mac_sched.sv
// multirate_mac_sched: decimating FIR branch sharing one external multiplier and coefficient ROM
module multirate_mac_sched
    import multirate_pkg::*;
#(
    parameter int NTAPS = 32,
    parameter int DECIM = 4,
    parameter int BANKS = 2,
    parameter int ACC_W = 36,
    parameter int OUT_SHIFT = 14
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [SAMPLE_W-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [clog2(BANKS)-1:0]       bank_sel,
    output logic [clog2(BANKS*NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]             coef_data,
    output logic [SAMPLE_W-1:0]           mul_din0,
    output logic [COEF_W-1:0]             mul_din1,
    input  logic [PROD_W-1:0]             mul_dout,
    output logic [SAMPLE_W-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready
);
    localparam int AW = clog2(NTAPS);
    localparam int PW = clog2(DECIM);
    localparam int BW = clog2(BANKS);
    localparam int CW = clog2(NTAPS + 4);
    localparam int CAW = clog2(BANKS * NTAPS);
    localparam logic [CW-1:0] C_NT = CW'(NTAPS);
    localparam logic [CW-1:0] C_NC = CW'(NTAPS + 1);
    localparam logic [CW-1:0] C_ND = CW'(NTAPS + 2);

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [SAMPLE_W-1:0]  mem_q [NTAPS];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, newest_q, newest_d, rd_idx;
    logic [AW:0]          rd_sum;
    logic [PW-1:0]        phase_q, phase_d;
    logic [BW-1:0]        bank_q, bank_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]  sample_q, sample_d;
    logic [PROD_W-1:0]    prod_q, prod_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [SAMPLE_W-1:0]  out_q, out_d, rs;
    logic                 mac, xfer, a_act, b_act, c_act, done;

    multirate_round_sat #(
        .ACC_W(ACC_W),
        .OUT_SHIFT(OUT_SHIFT),
        .OUT_W(SAMPLE_W)
    ) u_round_sat (
        .acc_i(acc_q),
        .out_o(rs)
    );

    // cnt_q walks the three-stage pipe: A fetches at 0..N-1, B multiplies at 1..N, C accumulates at 2..N+1
    always_comb begin
        mac = state_q == S_MAC;
        xfer = state_q == S_IDLE && in_valid && in_ready_q;
        a_act = mac && cnt_q < C_NT;
        b_act = mac && cnt_q != '0 && cnt_q <= C_NT;
        c_act = mac && cnt_q > CW'(1) && cnt_q <= C_NC;
        done = mac && cnt_q == C_ND;
        rd_sum = (AW + 1)'(newest_q) + (AW + 1)'(NTAPS) - (AW + 1)'(cnt_q);
        rd_idx = AW'(rd_sum >= (AW + 1)'(NTAPS) ? rd_sum - (AW + 1)'(NTAPS) : rd_sum);
        state_d = state_q;
        wr_ptr_d = wr_ptr_q;
        newest_d = newest_q;
        phase_d = phase_q;
        bank_d = bank_q;
        cnt_d = mac ? cnt_q + 1'b1 : cnt_q;
        sample_d = a_act ? mem_q[rd_idx] : sample_q;
        prod_d = b_act ? mul_dout : prod_q;
        acc_d = c_act ? acc_q + {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q} : acc_q;
        out_d = done ? rs : out_q;
        if (xfer) begin
            wr_ptr_d = wr_ptr_q == AW'(NTAPS - 1) ? '0 : wr_ptr_q + 1'b1;
            newest_d = wr_ptr_q;
            phase_d = phase_q == PW'(DECIM - 1) ? '0 : phase_q + 1'b1;
            if (phase_q == PW'(DECIM - 1)) begin
                bank_d = bank_sel;
                cnt_d = '0;
                acc_d = '0;
                state_d = S_MAC;
            end
        end
        if (done) state_d = S_OUT;
        if (state_q == S_OUT && out_ready) state_d = S_IDLE;
        in_ready_d = state_d == S_IDLE;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            in_ready_q <= 1'b0;
            for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            newest_q <= '0;
            phase_q <= '0;
            bank_q <= '0;
            cnt_q <= '0;
            sample_q <= '0;
            prod_q <= '0;
            acc_q <= '0;
            out_q <= '0;
        end else begin
            state_q <= state_d;
            in_ready_q <= in_ready_d;
            if (xfer) mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q <= wr_ptr_d;
            newest_q <= newest_d;
            phase_q <= phase_d;
            bank_q <= bank_d;
            cnt_q <= cnt_d;
            sample_q <= sample_d;
            prod_q <= prod_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_valid = state_q == S_OUT;
    assign out_data = out_q;
    assign coef_addr = a_act ? CAW'(int'(bank_q) * NTAPS + int'(cnt_q)) : '0;
    assign mul_din0 = b_act ? sample_q : '0;
    assign mul_din1 = b_act ? coef_data : '0;
endmodule

// File: tb/tb_multirate_mac_sched.sv
// tb_multirate_mac_sched: three scheduler configurations with bench-side ROMs and multipliers
module tb_multirate_mac_sched;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b1;
    always #5 ap_clk = ~ap_clk;

    logic [15:0] in_data [3];
    logic        in_valid [3];
    logic        out_ready [3];
    logic        bank_sel [3];
    logic        in_ready [3];
    logic        out_valid [3];
    logic [15:0] out_data [3];
    logic [15:0] mul_din0 [3];
    logic [14:0] mul_din1 [3];
    logic [7:0]  coef_addr [3];
    logic [14:0] coef_mem [3][64];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int din;
        int exp;
    } vec_t;
    vec_t tv [10];
    int sat_exp [16];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NT = g == 2 ? 32 : 4;
        localparam int DC = g == 0 ? 2 : g == 1 ? 1 : 4;
        localparam int AW = $clog2(2 * NT);
        logic [AW-1:0] ca;
        logic [14:0] cd;
        logic [14:0] m1;
        logic [15:0] m0;
        logic signed [31:0] p;
        logic [30:0] md;
        multirate_mac_sched #(
            .NTAPS(NT), .DECIM(DC), .BANKS(2), .ACC_W(36), .OUT_SHIFT(14)
        ) u_dut (
            .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
            .in_data(in_data[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .bank_sel(bank_sel[g]), .coef_addr(ca), .coef_data(cd),
            .mul_din0(m0), .mul_din1(m1), .mul_dout(md),
            .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g])
        );
        assign p = $signed(m0) * $signed({1'b0, m1});
        assign md = p[30:0];
        assign coef_addr[g] = 8'(ca);
        assign mul_din0[g] = m0;
        assign mul_din1[g] = m1;
        always @(posedge ap_clk) cd <= coef_mem[g][ca];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input int k, input int d);
        int n;
        @(negedge ap_clk);
        in_data[k] = 16'(d);
        in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (!in_ready[k]) chk("send_timeout", int'(in_ready[k]), 1);
        @(posedge ap_clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        @(negedge ap_clk);
        while (!out_valid[k] && lat < 400) begin
            @(negedge ap_clk);
            lat++;
        end
        if (!out_valid[k]) chk("out_timeout", int'(out_valid[k]), 1);
    endtask

    task automatic take(input int k);
        out_ready[k] = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic recv(input int k, output int d, output int lat);
        wait_valid(k, lat);
        d = int'($signed(out_data[k]));
        take(k);
    endtask

    task automatic do_reset(input bit check);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
            bank_sel[k] = 1'b0;
            in_data[k] = '0;
        end
        repeat (2) @(negedge ap_clk);
        if (check) for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready%0d", k), int'(in_ready[k]), 0);
            chk($sformatf("rst_out_valid%0d", k), int'(out_valid[k]), 0);
            chk($sformatf("rst_out_data%0d", k), int'(out_data[k]), 0);
            chk($sformatf("rst_coef_addr%0d", k), int'(coef_addr[k]), 0);
            chk($sformatf("rst_mul_din0_%0d", k), int'(mul_din0[k]), 0);
            chk($sformatf("rst_mul_din1_%0d", k), int'(mul_din1[k]), 0);
        end
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        if (check) for (int k = 0; k < 3; k++) chk($sformatf("post_rst_in_ready%0d", k), int'(in_ready[k]), 1);
    endtask

    task automatic impulse(input string tag);
        int d, lat;
        send(0, 1000);
        send(0, 0);
        recv(0, d, lat);
        chk({tag, "_lat"}, lat, 7);
        chk({tag, "_y0"}, d, 1000);
        send(0, 0);
        send(0, 0);
        recv(0, d, lat);
        chk({tag, "_y1"}, d, 1000);
        send(0, 0);
        send(0, 0);
        recv(0, d, lat);
        chk({tag, "_y2"}, d, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, lat, glitches;
        for (int i = 0; i < 64; i++) begin
            coef_mem[0][i] = i < 4 ? 15'd16384 : 15'd0;
            coef_mem[1][i] = 15'd0;
            coef_mem[2][i] = 15'd32767;
        end
        coef_mem[1][0] = 15'd16384;
        coef_mem[1][1] = 15'd8192;
        coef_mem[1][2] = 15'd4096;
        coef_mem[1][3] = 15'd2048;
        tv[0] = '{100, 100};
        tv[1] = '{200, 250};
        tv[2] = '{300, 425};
        tv[3] = '{400, 613};
        tv[4] = '{0, 300};
        tv[5] = '{-1, 137};
        tv[6] = '{0, 50};
        tv[7] = '{0, 0};
        tv[8] = '{-3, -3};
        tv[9] = '{0, -1};
        for (int i = 0; i < 16; i++) sat_exp[i] = i < 11 ? 32767 : -32768;
        sat_exp[11] = -32;

        do_reset(1'b1);
        impulse("imp");

        for (int i = 0; i < 10; i++) begin
            send(1, tv[i].din);
            recv(1, d, lat);
            chk($sformatf("tap_y%0d", i), d, tv[i].exp);
            if (i == 0) chk("tap_lat", lat, 7);
        end

        for (int i = 0; i < 64; i++) begin
            send(2, i < 32 ? 32767 : -32768);
            if (i % 4 == 3) begin
                recv(2, d, lat);
                chk($sformatf("sat_y%0d", i / 4), d, sat_exp[i / 4]);
                if (i == 3) chk("sat_lat", lat, 35);
            end
        end

        do_reset(1'b0);
        send(0, 10);
        send(0, 20);
        wait_valid(0, lat);
        chk("bp_y0", int'($signed(out_data[0])), 30);
        in_data[0] = 16'd30;
        in_valid[0] = 1'b1;
        glitches = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            if (out_data[0] != 16'd30 || in_ready[0] || !out_valid[0]) glitches++;
        end
        chk("bp_stall_glitches", glitches, 0);
        take(0);
        in_valid[0] = 1'b0;
        send(0, 30);
        send(0, 40);
        recv(0, d, lat);
        chk("bp_y1", d, 100);

        do_reset(1'b0);
        send(0, 7);
        send(0, 9);
        bank_sel[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            chk($sformatf("bank0_addr%0d", i), int'(coef_addr[0]), i);
        end
        recv(0, d, lat);
        chk("bank0_y", d, 16);
        send(0, 5);
        send(0, 6);
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            chk($sformatf("bank1_addr%0d", i), int'(coef_addr[0]), 4 + i);
        end
        recv(0, d, lat);
        chk("bank1_y", d, 0);

        do_reset(1'b0);
        send(0, 500);
        send(0, 500);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("rmac_out_valid", int'(out_valid[0]), 0);
        chk("rmac_in_ready", int'(in_ready[0]), 0);
        chk("rmac_coef_addr", int'(coef_addr[0]), 0);
        chk("rmac_mul_din0", int'(mul_din0[0]), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        send(0, 500);
        send(0, 500);
        wait_valid(0, lat);
        ap_rst_n = 1'b0;
        #1;
        chk("rout_out_valid", int'(out_valid[0]), 0);
        chk("rout_out_data", int'(out_data[0]), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        impulse("rst_imp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
